// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: request-side controller for the 256x128x8 SRAM macro.
// Optional power-on zero sweep: define SRAM_BURST_CTRL_CLEAR_EN.

module sram_burst_ctrl #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 8,
   parameter int LEN_W    = 8,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   output logic              sram_write_en,
   output logic              sram_sense_en,
   input  logic [DATA_W-1:0] sram_dout
);

   typedef enum logic [2:0] {CLEAR, IDLE, WRITE, READ, DRAIN} state_t;

`ifdef SRAM_BURST_CTRL_CLEAR_EN
   localparam state_t RST_STATE = CLEAR;
`else
   localparam state_t RST_STATE = IDLE;
`endif

   state_t            state, state_nxt;
   logic              hs, wr_go, rd_go, issue;
   logic              pop, push, credit_ok;
   logic              all_issued, clr_done;
   logic [3:0]        inflight, used;
   logic [ADDR_W-1:0] wr_addr, nxt_addr;
   logic [DATA_W-1:0] wr_data;
   logic [LEN_W-1:0]  len_q, iss_idx, out_cnt;
   logic [1:0]        pipe;
   logic [DATA_W-1:0] fifo_mem [4];
   logic [1:0]        wptr, rptr;
   logic [2:0]        fifo_cnt;

`ifdef SRAM_BURST_CTRL_CLEAR_EN
   logic [ADDR_W-1:0] clr_addr;
   assign clr_done = &clr_addr;
`else
   assign clr_done = 1'b1;
`endif

   // Credits: beats on the SRAM pins, in the capture pipe, and in the FIFO.
   assign inflight = 4'(sram_sense_en) + 4'(pipe[0])
                   + 4'(pipe[1] && (READ_LAT == 2));
   assign used = inflight + 4'(fifo_cnt) - 4'(pop);
   assign credit_ok = (used < 4'd4);
   assign all_issued = (iss_idx == len_q);

   assign push = pipe[READ_LAT-1];
   assign rd_valid = (fifo_cnt != 3'd0);
   assign rd_data = fifo_mem[rptr];
   assign rd_last = rd_valid && (out_cnt == len_q);
   assign pop = rd_valid && rd_ready;

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= RST_STATE;
      else         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         CLEAR: if (clr_done) state_nxt = IDLE;
         IDLE:  if (hs) state_nxt = req_write ? WRITE : READ;
         WRITE: state_nxt = IDLE;
         READ:  if (all_issued) state_nxt = DRAIN;
         DRAIN: if (used == 4'd0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake, issue decisions and status outputs.
   always_comb begin
      req_ready = 1'b0;
      busy      = 1'b0;
      if (resetn) begin
         req_ready = (state == IDLE);
         busy      = (state != IDLE);
      end
      hs      = req_valid && req_ready;
      wr_go   = (hs && req_write) || (state == CLEAR);
      rd_go   = hs && !req_write;
      issue   = rd_go || (state == READ && !all_issued && credit_ok);
      wr_addr = req_addr;
      wr_data = req_wdata;
`ifdef SRAM_BURST_CTRL_CLEAR_EN
      if (state == CLEAR) begin
         wr_addr = clr_addr;
         wr_data = '0;
      end
`endif
   end

   // Registered SRAM pins, burst address and beat counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sram_addr     <= '0;
         sram_din      <= '0;
         sram_write_en <= 1'b0;
         sram_sense_en <= 1'b0;
         nxt_addr      <= '0;
         len_q         <= '0;
         iss_idx       <= '0;
         out_cnt       <= '0;
         pipe          <= '0;
      end else begin
         sram_write_en <= wr_go;
         sram_sense_en <= issue;
         pipe          <= {pipe[0], sram_sense_en};
         if (wr_go) begin
            sram_addr <= wr_addr;
            sram_din  <= wr_data;
         end
         if (rd_go) begin
            sram_addr <= req_addr;
            nxt_addr  <= req_addr + ADDR_W'(1);
            len_q     <= req_len;
            iss_idx   <= '0;
         end else if (issue) begin
            sram_addr <= nxt_addr;
            nxt_addr  <= nxt_addr + ADDR_W'(1);
            iss_idx   <= iss_idx + LEN_W'(1);
         end
         if (rd_go)    out_cnt <= '0;
         else if (pop) out_cnt <= out_cnt + LEN_W'(1);
      end
   end

   // Read-data FIFO, four entries.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
         wptr     <= '0;
         rptr     <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            fifo_mem[wptr] <= sram_dout;
            wptr <= wptr + 2'd1;
         end
         if (pop) rptr <= rptr + 2'd1;
         fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
      end
   end

`ifdef SRAM_BURST_CTRL_CLEAR_EN
   // Sweep address for the power-on clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)              clr_addr <= '0;
      else if (state == CLEAR)  clr_addr <= clr_addr + ADDR_W'(1);
   end
`endif

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb_sram_burst_ctrl: directed bench for sram_burst_ctrl.
// Includes a behavioural SRAM macro with a one-cycle read latency.

module tb_sram_burst_ctrl;

   localparam int RL = 1;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [11:0] req_addr = '0;
   logic [7:0]  req_len = '0;
   logic [7:0]  req_wdata = '0;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [7:0]  rd_data;
   logic        rd_last;
   logic        busy;
   logic [11:0] sram_addr;
   logic [7:0]  sram_din;
   logic        sram_write_en;
   logic        sram_sense_en;
   logic [7:0]  sram_dout = '0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int first_lat;

   logic [11:0] we_addr [$];
   logic [7:0]  we_din [$];
   logic [11:0] se_addr [$];
   int          se_cyc [$];
   logic [7:0]  got_data [$];
   logic        got_last [$];
   int          got_cyc [$];

   logic [7:0] mem [4096];

   sram_burst_ctrl #(.READ_LAT(RL)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr),
      .req_len(req_len), .req_wdata(req_wdata),
      .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
      .sram_addr(sram_addr), .sram_din(sram_din),
      .sram_write_en(sram_write_en),
      .sram_sense_en(sram_sense_en),
      .sram_dout(sram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM macro model: nonzero power-up pattern, one-cycle read.
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 1);
      forever begin
         @(posedge clk);
         if (sram_write_en) mem[sram_addr] <= sram_din;
         if (sram_sense_en) sram_dout <= mem[sram_addr];
      end
   end

   // Pin activity log, sampled mid-cycle.
   always @(negedge clk) begin
      if (sram_write_en) begin
         we_addr.push_back(sram_addr);
         we_din.push_back(sram_din);
      end
      if (sram_sense_en) begin
         se_addr.push_back(sram_addr);
         se_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_req(input logic w, input logic [11:0] a,
                           input logic [7:0] l, input logic [7:0] d);
      int n = 0;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_len   = l;
      req_wdata = d;
      while (!req_ready && n < 6000) begin
         tick();
         n++;
      end
      tick();
      req_valid = 1'b0;
      checks++;
      if (n >= 6000) begin
         failures++;
         $display("FAIL req_handshake: req_ready stayed %b, required 1", req_ready);
      end
   endtask

   task automatic collect(input int n, input int budget);
      got_data.delete();
      got_last.delete();
      got_cyc.delete();
      first_lat = -1;
      for (int k = 1; k <= budget && got_data.size() < n; k++) begin
         if (rd_valid && rd_ready) begin
            if (first_lat < 0) first_lat = k;
            got_data.push_back(rd_data);
            got_last.push_back(rd_last);
            got_cyc.push_back(cyc);
         end
         tick();
      end
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 6000 && !req_ready; k++) tick();
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick();
      tick();
      checks++;
      if ({req_ready, busy, rd_valid, rd_last, sram_write_en, sram_sense_en} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b required 000000",
                  {req_ready, busy, rd_valid, rd_last, sram_write_en, sram_sense_en});
      end
      checks++;
      if (sram_addr !== 12'h0 || sram_din !== 8'h0 || rd_data !== 8'h0) begin
         failures++;
         $display("FAIL reset_data: addr=%h din=%h rd=%h required 0",
                  sram_addr, sram_din, rd_data);
      end
      #2 resetn = 1'b1;
      #1;
`ifdef SRAM_BURST_CTRL_CLEAR_EN
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL clear_entry: ready=%b busy=%b required 0/1", req_ready, busy);
      end
`else
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL release_ready: ready=%b busy=%b required 1/0", req_ready, busy);
      end
      tick();
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || sram_write_en !== 1'b0) begin
         failures++;
         $display("FAIL idle_hold: ready=%b busy=%b we=%b required 1/0/0",
                  req_ready, busy, sram_write_en);
      end
`endif
   endtask

`ifdef SRAM_BURST_CTRL_CLEAR_EN
   task automatic test_clear();
      int bad_seq = 0;
      int bad_rdy = 0;
      int n = 0;
      while (!req_ready && n < 5000) begin
         if (busy !== 1'b1) bad_rdy++;
         tick();
         n++;
      end
      checks++;
      if (we_addr.size() != 4096) begin
         failures++;
         $display("FAIL clear_count: got %0d writes required 4096", we_addr.size());
      end
      for (int i = 0; i < we_addr.size(); i++)
         if (we_addr[i] !== 12'(i) || we_din[i] !== 8'h00) bad_seq++;
      checks++;
      if (bad_seq != 0 || bad_rdy != 0) begin
         failures++;
         $display("FAIL clear_seq: %0d bad writes %0d busy drops required 0", bad_seq, bad_rdy);
      end
      rd_ready = 1'b1;
      send_req(1'b0, 12'h7FF, 8'd0, 8'h00);
      collect(1, 20);
      checks++;
      if (got_data.size() != 1 || got_data[0] !== 8'h00) begin
         failures++;
         $display("FAIL clear_read: got %0d beats data %h required 1 beat 00",
                  got_data.size(), got_data[0]);
      end
   endtask
`endif

   task automatic test_write_read();
      we_addr.delete();
      we_din.delete();
      rd_ready = 1'b1;
      send_req(1'b1, 12'h123, 8'd0, 8'hA5);
      checks++;
      if (sram_write_en !== 1'b1 || sram_addr !== 12'h123 || sram_din !== 8'hA5) begin
         failures++;
         $display("FAIL write_pins: we=%b addr=%h din=%h required 1/123/a5",
                  sram_write_en, sram_addr, sram_din);
      end
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL write_busy: ready=%b busy=%b required 0/1", req_ready, busy);
      end
      tick();
      checks++;
      if (sram_write_en !== 1'b0 || req_ready !== 1'b1 || we_addr.size() != 1) begin
         failures++;
         $display("FAIL write_pulse: we=%b ready=%b pulses=%0d required 0/1/1",
                  sram_write_en, req_ready, we_addr.size());
      end
      send_req(1'b0, 12'h123, 8'd0, 8'h00);
      checks++;
      if (sram_sense_en !== 1'b1 || sram_addr !== 12'h123 || sram_write_en !== 1'b0) begin
         failures++;
         $display("FAIL read_issue: se=%b addr=%h we=%b required 1/123/0",
                  sram_sense_en, sram_addr, sram_write_en);
      end
      collect(1, 20);
      checks++;
      if (got_data.size() != 1 || got_data[0] !== 8'hA5 || got_last[0] !== 1'b1) begin
         failures++;
         $display("FAIL read_back: beats=%0d data=%h last=%b required 1/a5/1",
                  got_data.size(), got_data[0], got_last[0]);
      end
      checks++;
      if (first_lat != RL + 2) begin
         failures++;
         $display("FAIL read_latency: got %0d required %0d", first_lat, RL + 2);
      end
      checks++;
      if (req_ready !== 1'b1 || rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL ready_after_last: ready=%b valid=%b required 1/0", req_ready, rd_valid);
      end
   endtask

   task automatic test_wrap_burst();
      logic [11:0] exp_a [4];
      exp_a[0] = 12'hFFE;
      exp_a[1] = 12'hFFF;
      exp_a[2] = 12'h000;
      exp_a[3] = 12'h001;
      for (int i = 0; i < 4; i++) send_req(1'b1, exp_a[i], 8'd0, 8'(8'h10 + i));
      tick();
      se_addr.delete();
      se_cyc.delete();
      rd_ready = 1'b1;
      send_req(1'b0, 12'hFFE, 8'd3, 8'h00);
      collect(4, 30);
      checks++;
      if (se_addr.size() != 4 || got_data.size() != 4) begin
         failures++;
         $display("FAIL wrap_counts: issues=%0d beats=%0d required 4/4",
                  se_addr.size(), got_data.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (se_addr[i] !== exp_a[i] || se_cyc[i] != se_cyc[0] + i) begin
            failures++;
            $display("FAIL wrap_issue%0d: addr=%h cyc_off=%0d required %h/%0d",
                     i, se_addr[i], se_cyc[i] - se_cyc[0], exp_a[i], i);
         end
         checks++;
         if (got_data[i] !== 8'(8'h10 + i) || got_last[i] !== (i == 3)) begin
            failures++;
            $display("FAIL wrap_beat%0d: data=%h last=%b required %h/%b",
                     i, got_data[i], got_last[i], 8'(8'h10 + i), (i == 3));
         end
      end
      checks++;
      if (got_cyc[3] - got_cyc[0] != 3) begin
         failures++;
         $display("FAIL wrap_rate: span=%0d required 3", got_cyc[3] - got_cyc[0]);
      end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      for (int i = 0; i < 16; i++) send_req(1'b1, 12'(12'h200 + i), 8'd0, 8'(8'h40 + i));
      tick();
      se_addr.delete();
      rd_ready = 1'b0;
      send_req(1'b0, 12'h200, 8'd15, 8'h00);
      repeat (20) tick();
      checks++;
      if (se_addr.size() != 4) begin
         failures++;
         $display("FAIL stall_issues: got %0d required 4", se_addr.size());
      end
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h40 || rd_last !== 1'b0 || sram_sense_en !== 1'b0) begin
         failures++;
         $display("FAIL stall_head: v=%b d=%h l=%b se=%b required 1/40/0/0",
                  rd_valid, rd_data, rd_last, sram_sense_en);
      end
      rd_ready = 1'b1;
      collect(16, 100);
      checks++;
      if (got_data.size() != 16 || se_addr.size() != 16) begin
         failures++;
         $display("FAIL stall_counts: beats=%0d issues=%0d required 16/16",
                  got_data.size(), se_addr.size());
      end
      for (int i = 0; i < 16; i++)
         if (got_data[i] !== 8'(8'h40 + i) || got_last[i] !== (i == 15)) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL stall_order: %0d bad beats required 0", bad);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL stall_idle: busy=%b valid=%b required 0/0", busy, rd_valid);
      end
   endtask

   task automatic test_reset_mid_burst();
      rd_ready = 1'b0;
      send_req(1'b0, 12'h100, 8'd15, 8'h00);
      repeat (3) tick();
      checks++;
      if (rd_valid !== 1'b1 || sram_sense_en !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre: v=%b se=%b busy=%b required 1/1/1",
                  rd_valid, sram_sense_en, busy);
      end
      #1 resetn = 1'b0;
      #1;
      checks++;
      if (rd_valid !== 1'b0 || sram_sense_en !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: v=%b se=%b busy=%b required 0/0/0",
                  rd_valid, sram_sense_en, busy);
      end
      tick();
      resetn = 1'b1;
      wait_ready();
      send_req(1'b1, 12'h300, 8'd0, 8'h5C);
      rd_ready = 1'b1;
      send_req(1'b0, 12'h300, 8'd0, 8'h00);
      collect(2, 12);
      checks++;
      if (got_data.size() != 1 || got_data[0] !== 8'h5C || got_last[0] !== 1'b1) begin
         failures++;
         $display("FAIL mid_after: beats=%0d data=%h last=%b required 1/5c/1",
                  got_data.size(), got_data[0], got_last[0]);
      end
   endtask

   initial begin
      we_addr.delete();
      test_reset();
`ifdef SRAM_BURST_CTRL_CLEAR_EN
      test_clear();
`endif
      test_write_read();
      test_wrap_burst();
      test_backpressure();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Request-side controller for the 4 KB 256x128x8 SRAM macro in the convolution datapath. It accepts single-beat write and multi-beat read requests over a valid/ready interface, and drives the macro's `addr`, `din`, `write_en` and `sense_en` pins. It captures `dout` after the macro's read latency and streams read data out through a small credit-guarded FIFO with backpressure. It sits directly upstream of the macro; the convolution engine talks only to this block.

## Interface
- `ADDR_W`, 12: SRAM address width (4096 bytes).
- `DATA_W`, 8: SRAM data width.
- `LEN_W`, 8: burst length field width; a burst is `req_len+1` beats.
- `READ_LAT`, 1: cycles from `sense_en` issue edge to valid `sram_dout`. Legal values are 1 and 2.
- `clk` in 1: single clock; all logic is on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_write` in 1: 1 = single-beat write, 0 = read burst.
- `req_addr` in ADDR_W: start address.
- `req_len` in LEN_W: beats minus 1; ignored for writes.
- `req_wdata` in DATA_W: write data.
- `rd_valid` out 1: read beat available.
- `rd_ready` in 1: consumer accepts the beat.
- `rd_data` out DATA_W: read beat.
- `rd_last` out 1: final beat of the burst.
- `busy` out 1: controller is not in IDLE.
- `sram_addr` out ADDR_W: to macro `addr11..addr0`.
- `sram_din` out DATA_W: to macro `din7..din0`.
- `sram_write_en` out 1: to macro `write_en`.
- `sram_sense_en` out 1: to macro `sense_en`.
- `sram_dout` in DATA_W: from macro `dout7..dout0`.

## Operation
- **Reset values:** all outputs 0, FSM in IDLE (or CLEAR, see Configuration), FIFO empty, no reads outstanding.
- **SRAM pins:** all SRAM-side outputs are registered. `sram_write_en` and `sram_sense_en` are never high in the same cycle. `sram_addr` and `sram_din` hold their last value when both enables are low.
- **FSM states:** CLEAR, IDLE, WRITE, READ, DRAIN.
- **IDLE:**
  - `req_ready=1`.
  - On handshake with `req_write=1`, go to WRITE.
  - On handshake with `req_write=0`, go to READ and latch `req_addr` and `req_len`.
- **WRITE:**
  - `sram_write_en=1` for exactly one cycle, with the latched address and data.
  - Then return to IDLE.
- **READ:**
  - Issue one address per cycle with `sram_sense_en=1`, but only when `outstanding + fifo_count < 4`.
  - After each issue the address increments, wrapping from 4095 to 0.
  - After issuing `len+1` beats, go to DRAIN.
- **Data capture:** the data for each issued beat is sampled `READ_LAT` cycles later and pushed into the 4-deep FIFO. The FIFO can never overflow because of the credit rule above.
- **Read output:** `rd_last` is flagged on the beat whose beat counter equals `len`. `rd_valid`, `rd_data` and `rd_last` present the FIFO head.
- **DRAIN:** wait until the FIFO is empty and nothing is outstanding, then return to IDLE.
- **Ordering:** all read data is delivered in address order. A new request is never accepted while read data is still pending.
- **Length arithmetic:** the beat counter is LEN_W bits. `req_len=255` gives 256 beats, with no overflow.
- **Asynchronous reset mid-operation:**
  - Outputs drop to their reset values immediately, including any in-progress `sram_write_en`.
  - In-flight read data is discarded.

## Timing
- **Write:** handshake at edge T. `sram_write_en` is high in cycle T+1, and `req_ready` is high again in cycle T+2.
- **Read issue:** handshake at edge T. The first `sram_sense_en` is in cycle T+1.
- **Read data:**
  - First data is pushed into the FIFO at edge T+1+READ_LAT.
  - `rd_valid` rises in the following cycle.
  - Request-to-first-beat latency is READ_LAT+2 cycles.
- **Steady state:** with `rd_ready` held high, the block sustains one beat per cycle.
- **Stalls:** with `rd_ready` low, issue stops once 4 credits are consumed. Issue resumes the cycle after a pop frees a credit.
- **Return to IDLE after a read:** `req_ready` reasserts the cycle after the handshake of the `rd_last` beat.
- **Output stability:** `rd_valid`, `rd_data` and `rd_last` stay stable while `rd_valid && !rd_ready`.

## Configuration
- Macro: `SRAM_BURST_CTRL_CLEAR_EN`.
- **Defined:**
  - On reset release the FSM enters CLEAR and writes 0 to addresses 0 through 4095, one per cycle (4096 cycles).
  - During CLEAR, `busy=1` and `req_ready=0`. The FSM then enters IDLE.
  - A reset during CLEAR restarts the sweep from address 0.
- **Undefined:**
  - The CLEAR state is absent and the FSM leaves reset in IDLE.
  - `req_ready=1` in the first cycle after `resetn` rises.

## Test plan
- Reset release (macro undefined) -> all outputs 0 during reset; `req_ready=1` in the first cycle after release; `busy=0`.
- Write 0xA5 to 0x123, then read with len=0 -> exactly one `sram_write_en` pulse with addr 0x123 and din 0xA5; the read returns `rd_data=0xA5` with `rd_last=1`, READ_LAT+2 cycles after the request.
- Preload 0xFFE..0x001 with 0x10..0x13, then read from 0xFFE with len=3 and `rd_ready=1` -> addresses FFE, FFF, 000, 001 issued on consecutive cycles; data 0x10..0x13 returned; `rd_last` only on the 4th beat.
- Read burst with len=15 and `rd_ready=0` for 20 cycles -> exactly 4 `sense_en` issues, then issue stalls; after `rd_ready` is raised, all 16 beats arrive in order with no loss or duplication.
- Assert `resetn` low mid-burst with beats in flight -> `rd_valid`, `sram_sense_en` and `busy` drop at once; after release, a new len=0 read returns the correct data only.
- With `SRAM_BURST_CTRL_CLEAR_EN` defined -> 4096 consecutive writes of 0 to addresses 0..4095, `req_ready=0` throughout; a read of 0x7FF afterwards returns 0x00.
